// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz views: result codes, round FSM encoding,
// view identifiers, host button bit positions and the buzz-in priority helper.
package quiz_pkg;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_OK      = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_JUDGE  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] VIEW_MENU    = 3'd0;
  localparam logic [2:0] VIEW_SETUP   = 3'd1;
  localparam logic [2:0] VIEW_SCORES  = 3'd2;
  localparam logic [2:0] VIEW_PLAY    = 3'd3;
  localparam logic [2:0] VIEW_INSPECT = 3'd4;

  localparam int BT_START   = 4;
  localparam int BT_CORRECT = 3;
  localparam int BT_WRONG   = 2;

  // Wide enough for the longest window (one billion cycles).
  localparam int TIMER_W = 30;

  // Player1 (bit 0) has the highest priority on simultaneous buzzes.
  function automatic logic [1:0] first_buzz(input logic [3:0] edges);
    if (edges[0])      return 2'd0;
    else if (edges[1]) return 2'd1;
    else if (edges[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/quiz_timer.sv
// Up-counter with synchronous clear (dominant over enable) and a terminal
// count flag raised while the count equals term_i.
module quiz_timer #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc_o = (count_q == term_i);

endmodule

// File: rtl/quiz_round_recorder.sv
// Runs one quiz question at a time in the play view and commits a 2-bit result
// per player into the answer lists. Optional beep on buzz-in: QUIZ_BUZZER_EN.
module quiz_round_recorder
  import quiz_pkg::*;
#(
  parameter int VIEW_ID      = 3,
  parameter int MAX_Q        = 9,
  parameter int BUZZ_TICKS   = 500_000_000,
  parameter int ANSWER_TICKS = 1_000_000_000,
  parameter int BEEP_TICKS   = 20_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           view,
  input  logic [4:0]           bt_edge,
  input  logic [3:0]           player_edge,
  output logic [3:0]           play_count,
  output logic [2*MAX_Q-1:0]   player1_list,
  output logic [2*MAX_Q-1:0]   player2_list,
  output logic [2*MAX_Q-1:0]   player3_list,
  output logic [2*MAX_Q-1:0]   player4_list,
  output logic                 round_done,
  output logic [23:0]          led,
  output logic                 buzzer
);

  localparam logic [3:0]         MAX_Q_C     = 4'(MAX_Q);
  localparam logic [TIMER_W-1:0] BUZZ_TERM   = TIMER_W'(BUZZ_TICKS - 1);
  localparam logic [TIMER_W-1:0] ANSWER_TERM = TIMER_W'(ANSWER_TICKS - 1);

  state_e                          state_q, state_d;
  logic [1:0]                      winner_q, winner_d;
  logic [1:0]                      code_q, code_d;
  logic [3:0]                      pc_q, pc_d;
  logic [3:0][2*MAX_Q-1:0]         lists_q, lists_d;
  logic                            view_ok;
  logic                            tmr_clr, tmr_en, tmr_tc;
  logic [TIMER_W-1:0]              tmr_term;
  logic [4:0]                      slot;

  assign view_ok  = (view == 3'(VIEW_ID));
  assign tmr_term = (state_q == ST_ARMED) ? BUZZ_TERM : ANSWER_TERM;
  assign slot     = {1'b0, pc_q} << 1;

  quiz_timer #(.W(TIMER_W)) u_round_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .term_i(tmr_term),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    code_d   = code_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    // Leaving the play view abandons an open question; DONE only yields to rst.
    if (!view_ok && state_q != ST_DONE) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bt_edge[BT_START] && pc_q < MAX_Q_C) begin
            state_d = ST_ARMED;
            tmr_clr = 1'b1;
          end
        end
        ST_ARMED: begin
          tmr_en = 1'b1;
          if (|player_edge) begin
            state_d  = ST_JUDGE;
            winner_d = first_buzz(player_edge);
            tmr_clr  = 1'b1;
          end else if (tmr_tc) begin
            state_d = ST_COMMIT;
            code_d  = RES_NONE;
          end
        end
        ST_JUDGE: begin
          tmr_en = 1'b1;
          if (bt_edge[BT_CORRECT]) begin
            state_d = ST_COMMIT;
            code_d  = RES_OK;
          end else if (bt_edge[BT_WRONG]) begin
            state_d = ST_COMMIT;
            code_d  = RES_WRONG;
          end else if (tmr_tc) begin
            state_d = ST_COMMIT;
            code_d  = RES_TIMEOUT;
          end
        end
        ST_COMMIT: begin
          tmr_clr = 1'b1;
          state_d = (pc_q + 4'd1 == MAX_Q_C) ? ST_DONE : ST_IDLE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lists_d = lists_q;
    pc_d    = pc_q;
    if (state_q == ST_COMMIT && view_ok) begin
      for (int p = 0; p < 4; p++) begin
        lists_d[p][slot +: 2] = (2'(p) == winner_q) ? code_q : RES_NONE;
      end
      pc_d = pc_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= 2'd0;
      code_q   <= RES_NONE;
      pc_q     <= 4'd0;
      lists_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      lists_q  <= lists_d;
    end
  end

  assign play_count   = pc_q;
  assign player1_list = lists_q[0];
  assign player2_list = lists_q[1];
  assign player3_list = lists_q[2];
  assign player4_list = lists_q[3];
  assign round_done   = (pc_q == MAX_Q_C);

  assign led = {state_q == ST_ARMED, state_q == ST_JUDGE, round_done, 9'd0,
                pc_q, 4'd0,
                (state_q == ST_JUDGE) ? (4'b0001 << winner_q) : 4'b0000};

  logic unused_ok;

`ifdef QUIZ_BUZZER_EN
  localparam logic [TIMER_W-1:0] BEEP_TERM = TIMER_W'(BEEP_TICKS - 1);
  logic beep_q, beep_tc, buzz_in;

  assign buzz_in = view_ok && state_q == ST_ARMED && (|player_edge);

  quiz_timer #(.W(TIMER_W)) u_beep_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (buzz_in || !beep_q),
    .en_i  (beep_q),
    .term_i(BEEP_TERM),
    .tc_o  (beep_tc)
  );

  always_ff @(posedge clk) begin
    if (rst || !view_ok)       beep_q <= 1'b0;
    else if (buzz_in)          beep_q <= 1'b1;
    else if (beep_q && beep_tc) beep_q <= 1'b0;
  end

  assign buzzer    = beep_q;
  assign unused_ok = &{1'b0, bt_edge[1:0]};
`else
  assign buzzer    = 1'b0;
  assign unused_ok = &{1'b0, bt_edge[1:0], BEEP_TICKS == 0};
`endif

endmodule

// File: tb/tb_quiz_round_recorder.sv
// Directed bench for quiz_round_recorder with short windows (20/30/5 cycles).
module tb_quiz_round_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  view;
  logic [4:0]  bt_edge;
  logic [3:0]  player_edge;
  logic [3:0]  play_count;
  logic [17:0] player1_list, player2_list, player3_list, player4_list;
  logic        round_done;
  logic [23:0] led;
  logic        buzzer;

  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] exp_list [4];
  logic [3:0]  exp_pc;

  always #5 clk = ~clk;

  quiz_round_recorder #(
    .VIEW_ID(3), .MAX_Q(9), .BUZZ_TICKS(20), .ANSWER_TICKS(30), .BEEP_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .view(view), .bt_edge(bt_edge), .player_edge(player_edge),
    .play_count(play_count), .player1_list(player1_list), .player2_list(player2_list),
    .player3_list(player3_list), .player4_list(player4_list), .round_done(round_done),
    .led(led), .buzzer(buzzer)
  );

  function automatic logic [17:0] act_list(input int p);
    case (p)
      0:       return player1_list;
      1:       return player2_list;
      2:       return player3_list;
      default: return player4_list;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] v);
    @(negedge clk) bt_edge = v;
    @(negedge clk) bt_edge = 5'b0;
  endtask

  task automatic buzz(input logic [3:0] v);
    @(negedge clk) player_edge = v;
    @(negedge clk) player_edge = 4'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; view = 3'd3; bt_edge = 5'b0; player_edge = 4'b0;
    tick(3);
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", play_count); end
    n_vec++; if (led !== 24'd0) begin n_err++; $display("FAIL reset_led: got %h want 000000", led); end
    n_vec++; if ({round_done, buzzer} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {round_done, buzzer}); end
    for (int p = 0; p < 4; p++) begin
      exp_list[p] = 18'd0;
      n_vec++; if (act_list(p) !== 18'd0) begin n_err++; $display("FAIL reset_list%0d: got %h want 0", p + 1, act_list(p)); end
    end
    exp_pc = 4'd0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_correct;
    press(5'b10000);
    n_vec++; if (led[23:22] !== 2'b10) begin n_err++; $display("FAIL armed_led: got %b want 10", led[23:22]); end
    buzz(4'b0100);
    n_vec++; if (led[3:0] !== 4'b0100) begin n_err++; $display("FAIL judge_winner: got %b want 0100", led[3:0]); end
    n_vec++; if (led[22] !== 1'b1) begin n_err++; $display("FAIL judge_led: got %b want 1", led[22]); end
    press(5'b01000);
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL commit_latency: got %0d want %0d", play_count, exp_pc); end
    tick(1);
    exp_list[2][1:0] = 2'b01; exp_pc = 4'd1;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q1_pc: got %0d want %0d", play_count, exp_pc); end
    n_vec++; if (led[11:8] !== exp_pc) begin n_err++; $display("FAIL q1_led_pc: got %0d want %0d", led[11:8], exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q1_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
  endtask

  task automatic test_simultaneous;
    press(5'b10000);
    buzz(4'b0011);
    n_vec++; if (led[3:0] !== 4'b0001) begin n_err++; $display("FAIL simul_winner: got %b want 0001", led[3:0]); end
    press(5'b00100);
    tick(1);
    exp_list[0][3:2] = 2'b10; exp_pc = 4'd2;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q2_pc: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q2_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
  endtask

  task automatic test_timeouts;
    press(5'b10000);
    tick(19);
    n_vec++; if (led[23] !== 1'b1) begin n_err++; $display("FAIL buzz_window_last: got %b want 1", led[23]); end
    tick(1);
    n_vec++; if (led[23:22] !== 2'b00) begin n_err++; $display("FAIL buzz_window_end: got %b want 00", led[23:22]); end
    tick(1);
    exp_pc = 4'd3;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q3_pc: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q3_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
    press(5'b10000);
    buzz(4'b0010);
    tick(29);
    n_vec++; if (led[22] !== 1'b1) begin n_err++; $display("FAIL answer_window_last: got %b want 1", led[22]); end
    tick(1);
    n_vec++; if (led[22] !== 1'b0) begin n_err++; $display("FAIL answer_window_end: got %b want 0", led[22]); end
    tick(1);
    exp_list[1][7:6] = 2'b11; exp_pc = 4'd4;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q4_pc: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q4_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
  endtask

  task automatic test_view_change;
    press(5'b10000);
    buzz(4'b1000);
    n_vec++; if (led[3:0] !== 4'b1000) begin n_err++; $display("FAIL view_judge: got %b want 1000", led[3:0]); end
    @(negedge clk) view = 3'd4;
    @(negedge clk);
    n_vec++; if (led[23:22] !== 2'b00) begin n_err++; $display("FAIL view_idle: got %b want 00", led[23:22]); end
    press(5'b01000);
    tick(2);
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL view_pc_kept: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL view_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
    @(negedge clk) view = 3'd3;
    press(5'b10000);
    buzz(4'b1000);
    press(5'b01000);
    tick(1);
    exp_list[3][9:8] = 2'b01; exp_pc = 4'd5;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q5_pc: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q5_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
  endtask

  task automatic test_buzzer_and_ignores;
    int hi;
    int exp_hi;
`ifdef QUIZ_BUZZER_EN
    exp_hi = 5;
`else
    exp_hi = 0;
`endif
    hi = 0;
    press(5'b10000);
    buzz(4'b0001);
    for (int i = 0; i < 10; i++) begin
      if (buzzer === 1'b1) hi++;
      @(negedge clk);
    end
    n_vec++; if (hi !== exp_hi) begin n_err++; $display("FAIL buzzer_cycles: got %0d want %0d", hi, exp_hi); end
    buzz(4'b0010);
    n_vec++; if (led[3:0] !== 4'b0001) begin n_err++; $display("FAIL late_buzz_ignored: got %b want 0001", led[3:0]); end
    press(5'b10000);
    n_vec++; if (led[23:22] !== 2'b01) begin n_err++; $display("FAIL start_in_judge: got %b want 01", led[23:22]); end
    press(5'b01100);
    tick(1);
    exp_list[0][11:10] = 2'b01; exp_pc = 4'd6;
    n_vec++; if (play_count !== exp_pc) begin n_err++; $display("FAIL q6_pc: got %0d want %0d", play_count, exp_pc); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL q6_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] who [3];
    logic [4:0] verdict [3];
    logic [1:0] code [3];
    who = '{4'b0010, 4'b0100, 4'b1000};
    verdict = '{5'b00100, 5'b01000, 5'b00100};
    code = '{2'b10, 2'b01, 2'b10};
    for (int q = 0; q < 3; q++) begin
      press(5'b10000);
      buzz(who[q]);
      press(verdict[q]);
      tick(1);
      exp_list[q + 1][2 * (q + 6) +: 2] = code[q];
      exp_pc = exp_pc + 4'd1;
    end
    n_vec++; if (play_count !== 4'd9) begin n_err++; $display("FAIL full_pc: got %0d want 9", play_count); end
    n_vec++; if (round_done !== 1'b1) begin n_err++; $display("FAIL round_done: got %b want 1", round_done); end
    n_vec++; if ({led[21], led[11:8]} !== 5'b11001) begin n_err++; $display("FAIL done_led: got %b want 11001", {led[21], led[11:8]}); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL full_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
    press(5'b10000);
    buzz(4'b0001);
    press(5'b10000);
    press(5'b01000);
    tick(2);
    n_vec++; if (play_count !== 4'd9) begin n_err++; $display("FAIL done_pc_hold: got %0d want 9", play_count); end
    n_vec++; if (led[23:22] !== 2'b00) begin n_err++; $display("FAIL done_no_arm: got %b want 00", led[23:22]); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== exp_list[p]) begin n_err++; $display("FAIL done_list%0d: got %h want %h", p + 1, act_list(p), exp_list[p]); end
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    n_vec++; if ({round_done, play_count} !== 5'd0) begin n_err++; $display("FAIL rerst_pc: got %b want 00000", {round_done, play_count}); end
    for (int p = 0; p < 4; p++) begin
      n_vec++; if (act_list(p) !== 18'd0) begin n_err++; $display("FAIL rerst_list%0d: got %h want 0", p + 1, act_list(p)); end
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_simultaneous;
    test_timeouts;
    test_view_change;
    test_buzzer_and_ignores;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
